trap_ctrl: RTL
==============

// Module: trap_ctrl
// PURPOSE
//  Machine-mode trap/interrupt sequencer for the single-cycle RV32 core. Takes ecall/ebreak/mret
//  from the decoder plus timer/external IRQ lines. Owns mstatus/mie/mip/mtvec/mepc/mcause.
//  Stalls the core, then issues a one-cycle PC redirect to the trap vector or to mepc.
//  Sits beside the decoder/CSR writeback path; redirect_pc_o feeds the PC-next mux.
// PARAMETERS
//  XLEN         32             datapath width
//  MTVEC_RESET  32'h0000_0100  mtvec reset value
//  VECTORED_EN  1              1: honour mtvec.MODE=1 (vectored); 0: MODE bit reads 0, always direct
// PORTS
//  clk               in   1     rising-edge clock
//  rst               in   1     synchronous, active-high reset
//  pc_i              in   XLEN  PC of instruction in execute
//  ecall_i           in   1     decoder: ECALL
//  ebreak_i          in   1     decoder: EBREAK
//  mret_i            in   1     decoder: MRET
//  timer_irq_i       in   1     level machine-timer IRQ
//  ext_irq_i         in   1     level machine-external IRQ
//  csr_addr_i        in   12    CSR address
//  csr_we_i          in   1     CSR write strobe
//  csr_wdata_i       in   XLEN  CSR write data
//  csr_rdata_o       out  XLEN  CSR read data (combinational from csr_addr_i)
//  stall_o           out  1     hold PC, suppress RF/DM writes
//  redirect_valid_o  out  1     load redirect_pc_o into PC this cycle (registered)
//  redirect_pc_o     out  XLEN  redirect target (registered)
// BEHAVIOUR
//  - FSM: IDLE, REDIRECT. Events are sampled only in IDLE; ignored in REDIRECT.
//  - irq_take = mstatus.MIE & ((mie.MEIE & ext_irq_i) | (mie.MTIE & timer_irq_i)).
//  - Priority in IDLE: MEI > MTI > ecall > ebreak > mret.
//    If an IRQ is taken alongside an ecall/ebreak/mret, the instruction is killed and replays after MRET.
//  - Cycle N (IDLE, event): stall_o=1.
//    At edge: mepc<=pc_i & ~3; state<=REDIRECT; redirect_pc_o<=target.
//    For traps also: mcause<=code, MPIE<=MIE, MIE<=0.
//    For mret: MIE<=MPIE, MPIE<=1, target=mepc.
//  - Cycle N+1 (REDIRECT): stall_o=1, redirect_valid_o=1. Next state IDLE. Total latency 2 cycles.
//  - Cause codes: ecall 11, ebreak 3, MTI 0x8000_0007, MEI 0x8000_000B.
//  - Target: direct = {mtvec[XLEN-1:2],2'b00}.
//    Vectored (MODE=1) = base + 4*cause[4:0] for interrupts; base for exceptions.
//  - stall_o = ~rst & ((IDLE & (irq_take|ecall_i|ebreak_i|mret_i)) | REDIRECT).
//  - CSRs (addr / writable bits / read):
//      mstatus 0x300  MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; all else 0
//      mie     0x304  MTIE[7], MEIE[11]
//      mtvec   0x305  base[XLEN-1:2], MODE[0]; bit1 reads 0
//      mepc    0x341  [XLEN-1:2]; [1:0] read 0
//      mcause  0x342  full XLEN
//      mip     0x344  read-only, {ext_irq_i@11, timer_irq_i@7}
//  - Unmapped addresses: read 0, writes ignored.
//  - CSR write in an event cycle is suppressed; trap/mret update wins. CSR writes in REDIRECT are also ignored.
//  - Reset: state IDLE; redirect_valid_o=0; redirect_pc_o=0; stall_o=0 while rst high.
//    mstatus MIE=MPIE=0; mie=0; mtvec=MTVEC_RESET; mepc=0; mcause=0.
//  - rst in REDIRECT aborts the redirect: next cycle IDLE, redirect_valid_o=0, CSRs at reset values.
//  - IRQ deasserted before being taken: no trap (level-sensitive, no latching).
// STRUCTURE
//  - Package riscv_csr_pkg: CSR address localparams, cause-code localparams,
//    mstatus/mie bit indices, trap_state_e {IDLE, REDIRECT}.
//  - Sub-module trap_csr_regs: CSR storage, write masking, read mux, mip composition.
//    trap_ctrl holds the FSM, priority encoder, target calculation and output registers.
// TESTING
//  1 Reset: rst 1 cycle -> mtvec reads 0x100, mstatus reads 0x1800, stall_o=0, redirect_valid_o=0.
//  2 ecall at pc 0x40, mtvec=0x200, MIE=1 -> stall_o=1 in N and N+1; redirect_valid_o=1/pc 0x200 in N+1.
//    After: mepc=0x40, mcause=11, mstatus=0x1880.
//  3 mret with mepc=0x44, MPIE=1 -> redirect 0x44 in N+1; mstatus=0x1888.
//  4 mtvec=0x201, MIE=1, mie=0x80, timer_irq_i=1 at pc 0x80 -> redirect 0x21C.
//    mcause=0x8000_0007, mepc=0x80.
//  5 ext+timer IRQs + ecall_i same cycle, all enabled, mtvec=0x201 -> mcause=0x8000_000B,
//    redirect 0x22C, ecall not recorded.
//  6 MIE=0 with both IRQs high -> stall_o=0 for 10 cycles; mip reads 0x880.
//    rst asserted in REDIRECT -> redirect_valid_o=0 next cycle, state IDLE.

Source files
------------

// File: rtl/riscv_csr_pkg.sv
// Shared CSR addresses, cause codes, bit positions and trap FSM state type
// for the machine-mode trap controller.
package riscv_csr_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] CAUSE_EBREAK = 32'h0000_0003;
    localparam logic [XLEN-1:0] CAUSE_ECALL  = 32'h0000_000B;
    localparam logic [XLEN-1:0] CAUSE_MTI    = 32'h8000_0007;
    localparam logic [XLEN-1:0] CAUSE_MEI    = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } trap_state_e;

    // Interrupts jump to base + 4*cause in vectored mode; exceptions always use base.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                    input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[0] && cause[XLEN-1]) begin
            return base + XLEN'({cause[4:0], 2'b00});
        end
        return base;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Core-side bus of the trap controller: event lines, CSR access and PC redirect.
interface trap_ctrl_if;
    import riscv_csr_pkg::*;

    logic [XLEN-1:0] pc_i;
    logic            ecall_i;
    logic            ebreak_i;
    logic            mret_i;
    logic            timer_irq_i;
    logic            ext_irq_i;
    logic [11:0]     csr_addr_i;
    logic            csr_we_i;
    logic [XLEN-1:0] csr_wdata_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            stall_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output pc_i, ecall_i, ebreak_i, mret_i, timer_irq_i, ext_irq_i,
               csr_addr_i, csr_we_i, csr_wdata_i,
        input  csr_rdata_o, stall_o, redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  pc_i, ecall_i, ebreak_i, mret_i, timer_irq_i, ext_irq_i,
               csr_addr_i, csr_we_i, csr_wdata_i,
        output csr_rdata_o, stall_o, redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/trap_csr_regs.sv
// Machine-mode CSR storage: write masking, trap/mret side effects, read mux, mip.
module trap_csr_regs
    import riscv_csr_pkg::*;
#(
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            timer_irq_i,
    input  logic            ext_irq_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] cause_i,
    input  logic [XLEN-1:0] epc_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            mstatus_mie_o,
    output logic            mie_mtie_o,
    output logic            mie_meie_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    // MODE bit only survives when vectored mode is supported; bit 1 never does.
    localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] EPC_MASK   = 32'hFFFF_FFFC;

    logic            mie_bit_q, mie_bit_d;
    logic            mpie_q, mpie_d;
    logic            mtie_q, mtie_d;
    logic            meie_q, meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit_q <= 1'b0;
            mpie_q    <= 1'b0;
            mtie_q    <= 1'b0;
            meie_q    <= 1'b0;
            mtvec_q   <= MTVEC_RESET & MTVEC_MASK;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            mie_bit_q <= mie_bit_d;
            mpie_q    <= mpie_d;
            mtie_q    <= mtie_d;
            meie_q    <= meie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    // Trap/mret updates take precedence over software CSR writes.
    always_comb begin
        mie_bit_d = mie_bit_q;
        mpie_d    = mpie_q;
        mtie_d    = mtie_q;
        meie_d    = meie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (trap_i) begin
            mepc_d    = epc_i & EPC_MASK;
            mcause_d  = cause_i;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret_i) begin
            mepc_d    = epc_i & EPC_MASK;
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end else if (csr_we_i) begin
            unique case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_bit_d = csr_wdata_i[MSTATUS_MIE];
                    mpie_d    = csr_wdata_i[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mtie_d = csr_wdata_i[MIE_MTIE];
                    meie_d = csr_wdata_i[MIE_MEIE];
                end
                CSR_MTVEC:  mtvec_d  = csr_wdata_i & MTVEC_MASK;
                CSR_MEPC:   mepc_d   = csr_wdata_i & EPC_MASK;
                CSR_MCAUSE: mcause_d = csr_wdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        unique case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[12:11]        = 2'b11;
                csr_rdata_o[MSTATUS_MPIE] = mpie_q;
                csr_rdata_o[MSTATUS_MIE]  = mie_bit_q;
            end
            CSR_MIE: begin
                csr_rdata_o[MIE_MTIE] = mtie_q;
                csr_rdata_o[MIE_MEIE] = meie_q;
            end
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            CSR_MIP: begin
                csr_rdata_o[MIE_MTIE] = timer_irq_i;
                csr_rdata_o[MIE_MEIE] = ext_irq_i;
            end
            default: ;
        endcase
    end

    assign mstatus_mie_o = mie_bit_q;
    assign mie_mtie_o    = mtie_q;
    assign mie_meie_o    = meie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: prioritises events, stalls the core and
// issues a one-cycle registered PC redirect to the trap vector or to mepc.
module trap_ctrl
    import riscv_csr_pkg::*;
#(
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
    parameter bit              VECTORED_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctrl_if.slave bus
);

    trap_state_e     state_q, state_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            mstatus_mie;
    logic            mie_mtie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic            take_mei;
    logic            take_mti;
    logic            trap_c;
    logic            mret_c;
    logic            stall_c;
    logic [XLEN-1:0] cause_c;

    assign take_mei = mstatus_mie & mie_meie & bus.ext_irq_i;
    assign take_mti = mstatus_mie & mie_mtie & bus.timer_irq_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Events are only accepted in IDLE; a taken IRQ kills any coincident instruction event.
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        trap_c           = 1'b0;
        mret_c           = 1'b0;
        stall_c          = 1'b0;
        cause_c          = '0;
        unique case (state_q)
            IDLE: begin
                if (take_mei) begin
                    trap_c  = 1'b1;
                    cause_c = CAUSE_MEI;
                end else if (take_mti) begin
                    trap_c  = 1'b1;
                    cause_c = CAUSE_MTI;
                end else if (bus.ecall_i) begin
                    trap_c  = 1'b1;
                    cause_c = CAUSE_ECALL;
                end else if (bus.ebreak_i) begin
                    trap_c  = 1'b1;
                    cause_c = CAUSE_EBREAK;
                end else if (bus.mret_i) begin
                    mret_c = 1'b1;
                end
                if (trap_c || mret_c) begin
                    stall_c          = 1'b1;
                    state_d          = REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mret_c ? mepc : trap_target(mtvec, cause_c);
                end
            end
            REDIRECT: begin
                stall_c = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    trap_csr_regs #(
        .MTVEC_RESET (MTVEC_RESET),
        .VECTORED_EN (VECTORED_EN)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .csr_addr_i    (bus.csr_addr_i),
        .csr_we_i      (bus.csr_we_i && (state_q == IDLE) && !(trap_c || mret_c)),
        .csr_wdata_i   (bus.csr_wdata_i),
        .timer_irq_i   (bus.timer_irq_i),
        .ext_irq_i     (bus.ext_irq_i),
        .trap_i        (trap_c),
        .mret_i        (mret_c),
        .cause_i       (cause_c),
        .epc_i         (bus.pc_i),
        .csr_rdata_o   (bus.csr_rdata_o),
        .mstatus_mie_o (mstatus_mie),
        .mie_mtie_o    (mie_mtie),
        .mie_meie_o    (mie_meie),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc)
    );

    assign bus.stall_o          = stall_c & ~rst;
    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;

endmodule
